ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0, req1  input  1 each  access request from requester 0/1; held high until gnt seen.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN high.
REQ-007 addr0, addr1  input  ADDR_W each  access address; valid while reqN high.
REQ-008 wdata0, wdata1  input  DATA_W each  write data; valid while reqN high.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse, registered.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle read-data-valid pulse, registered.
REQ-011 rdata  output  DATA_W  read data, shared, qualified by rvalid0/rvalid1.
REQ-012 ram_en  output  1  RAM write enable (1 = write at edge, 0 = read).
REQ-013 ram_addr  output  ADDR_W  RAM address.
REQ-014 ram_data_in  output  DATA_W  RAM write data.
REQ-015 ram_data_out  input  DATA_W  RAM read data, valid one cycle after ram_addr presented with ram_en=0.

Function
REQ-016 FSM states IDLE, GRANT, RDATA; exactly one encoding in shared package.
REQ-017 IDLE: no request -> stay IDLE; any reqN high at edge -> GRANT, winner latched (index, we, addr, wdata).
REQ-018 Arbitration round-robin: both requesting -> grant requester not granted last; single requester always wins.
REQ-019 Last-grant pointer resets to 1, so requester 0 wins first simultaneous contest.
REQ-020 GRANT (exactly one cycle): gntN=1 for winner only; ram_addr=latched addr; ram_en=latched we; ram_data_in=latched wdata.
REQ-021 GRANT with write -> IDLE; write commits at the GRANT->IDLE edge; no rvalid.
REQ-022 GRANT with read -> RDATA; RDATA (one cycle): rvalidN=1 for winner, rdata=ram_data_out.
REQ-023 RDATA -> IDLE unconditionally.
REQ-024 Latency: request sampled at edge k -> gnt in cycle k+1 -> rvalid in cycle k+2; write throughput 1 per 2 cycles, read 1 per 3 cycles.
REQ-025 Requests are sampled only in IDLE; req changes during GRANT/RDATA are ignored; req still high in next IDLE is a new request.
REQ-026 Outside GRANT: ram_en=0; ram_addr and ram_data_in hold last latched values.
REQ-027 gnt0 and gnt1 never both high; rvalid0 and rvalid1 never both high; no gnt during RDATA.
REQ-028 rdata holds its last value outside RDATA.
REQ-029 Request dropped before grant: access abandoned only if req low at the IDLE sampling edge.

Reset
REQ-030 rst high asynchronously forces IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, ram_en=0, ram_addr=0, ram_data_in=0, rdata=0, last-grant pointer=1.
REQ-031 rst asserted during GRANT of a write: ram_en drops immediately, write not guaranteed; during RDATA: rvalid drops immediately, read lost.
REQ-032 First grant possible at the second rising edge after rst deasserts (first edge samples req).

Structure
REQ-033 Package ram_arb_pkg holds state enum, ADDR_W/DATA_W defaults and requester-index type.
REQ-034 Round-robin pick is a sub-module rr_pick2 (inputs req0, req1, last; outputs winner, valid), purely combinational.
REQ-035 All outputs driven from registers; no combinational path from reqN to gntN or ram_*.

Verification
REQ-036 Reset: rst=1 for 20 ns, req0=1 throughout -> all outputs 0; gnt0 first at second edge after release.
REQ-037 Single write then read: req0, we0=1, addr0=3, wdata0=8'hA5 -> gnt0 one cycle, ram_en=1, ram_addr=3; then read addr0=3 -> rvalid0 with rdata=8'hA5 two cycles after sampling.
REQ-038 Contention: req0 and req1 both held for reads -> gnt0, gnt1, gnt0, gnt1 alternating, every grant 3 cycles apart, rvalid matches granted requester.
REQ-039 Write/read cross: req1 writes addr 7 = 8'h3C while req0 queued read addr 7 -> order per pointer; read returns 8'h3C if write granted first, else old contents.
REQ-040 Mid-operation reset: rst pulsed during RDATA -> rvalid drops same cycle, FSM in IDLE, pointer=1, next simultaneous request granted to requester 0.
REQ-041 Assertions over random traffic: gnt one-hot-or-zero, rvalid one-hot-or-zero, ram_en high only in GRANT.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester single-port RAM arbiter.
// Holds the FSM encoding so every file agrees on the state values.
package ram_arb_pkg;

  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

  // Requester index: 0 or 1.
  typedef logic req_idx_t;

  function automatic req_idx_t other_req(input req_idx_t idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: on contention the requester that
// was not granted last wins; a lone requester always wins.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  req_idx_t last,
  output req_idx_t winner,
  output logic     valid
);

  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = other_req(last);
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  assign valid = req0 | req1;

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one synchronous single-port RAM.
// IDLE samples requests, GRANT drives the RAM for one cycle, RDATA returns reads.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_t            state_reg;
  req_idx_t          last_reg;
  req_idx_t          win_reg;
  logic              we_reg;
  logic [DATA_W-1:0] rdata_reg;

  req_idx_t pick_winner;
  logic     pick_valid;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last_reg),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // The RAM output register is valid during RDATA, so rdata passes it through
  // then and otherwise shows the value captured at the end of the last read.
  assign rdata = (rvalid0 | rvalid1) ? ram_data_out : rdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      last_reg    <= 1'b1;
      win_reg     <= 1'b0;
      we_reg      <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      ram_en      <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      rdata_reg   <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      ram_en  <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            state_reg   <= ST_GRANT;
            win_reg     <= pick_winner;
            last_reg    <= pick_winner;
            we_reg      <= pick_winner ? we1 : we0;
            ram_en      <= pick_winner ? we1 : we0;
            ram_addr    <= pick_winner ? addr1 : addr0;
            ram_data_in <= pick_winner ? wdata1 : wdata0;
            gnt0        <= ~pick_winner;
            gnt1        <= pick_winner;
          end
        end
        ST_GRANT: begin
          if (we_reg) begin
            state_reg <= ST_IDLE;
          end else begin
            state_reg <= ST_RDATA;
            rvalid0   <= ~win_reg;
            rvalid1   <= win_reg;
          end
        end
        ST_RDATA: begin
          state_reg <= ST_IDLE;
          rdata_reg <= ram_data_out;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
